// File: rtl/clause_loader_pkg.sv
// -----------------------------------------------------------------------------
// clause_loader_pkg
// Definitions shared by the clause loader and its coefficient assembler:
//   - state_t          : loader FSM state encoding
//   - IDLE_INDEX       : all-ones index code that leaves every clause register
//                        unwritten; users slice it down to their index width
//   - coeffs_per_clause: coefficients per clause (variables plus one bias)
// -----------------------------------------------------------------------------
package clause_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Wide enough for any practical index bus; slice [IW-1:0] at the use site.
   localparam int                      MAX_INDEX_W = 32;
   localparam logic [MAX_INDEX_W-1:0] IDLE_INDEX  = '1;

   // The bias coefficient always follows the variable coefficients.
   function automatic int coeffs_per_clause(input int num_variables);
      return num_variables + 1;
   endfunction

endpackage

// File: rtl/clause_loader_assembler.sv
// -----------------------------------------------------------------------------
// clause_loader_assembler  (coefficient_assembler)
// Beat counter plus slot-write assembly register for one clause.
// Ports:
//   in_clk, in_reset    : clock / asynchronous active-high reset
//   in_clear            : restart assembly at slot 0
//   in_accept           : a beat is being accepted this cycle
//   in_coefficient      : beat payload, written into the current slot
//   out_beat_last       : current slot is the last one (bias) of the clause
//   out_vector_next     : assembled vector including the beat on the input,
//                         i.e. the complete clause when out_beat_last&&in_accept
// -----------------------------------------------------------------------------
module clause_loader_assembler
   import clause_loader_pkg::*;
#(
   parameter int C = 2,
   parameter int K = 3
) (
   input  logic             in_clk,
   input  logic             in_reset,
   input  logic             in_clear,
   input  logic             in_accept,
   input  logic [C-1:0]     in_coefficient,
   output logic             out_beat_last,
   output logic [C*K-1:0]   out_vector_next
);

   localparam int BW = (K > 1) ? $clog2(K) : 1;

   logic [BW-1:0]  beat_count;
   logic [C*K-1:0] assembly;

   assign out_beat_last = (beat_count == BW'(K - 1));

   // Beat counter: wraps only through an explicit clear or the last beat.
   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         beat_count <= '0;
      end else if (in_clear) begin
         beat_count <= '0;
      end else if (in_accept) begin
         if (out_beat_last) beat_count <= '0;
         else               beat_count <= beat_count + BW'(1);
      end
   end

   // Slot storage is pure data; every slot is rewritten before it is used.
   always_ff @(posedge in_clk) begin
      if (in_accept) assembly[int'(beat_count)*C +: C] <= in_coefficient;
   end

   // Merge the in-flight beat so the owner can register the whole clause on
   // the same edge that accepts the final coefficient.
   always_comb begin
      out_vector_next = assembly;
      out_vector_next[int'(beat_count)*C +: C] = in_coefficient;
   end

endmodule

// File: rtl/clause_loader.sv
// -----------------------------------------------------------------------------
// clause_loader
// Streams coefficients (one per beat, valid/ready) into a clause vector and
// presents each finished clause with its index for exactly one cycle, writing
// clauses 0 .. NUMBER_OF_CLAUSES-1 in order, then pulses out_done.
// Ports:
//   in_clk, in_reset         : clock / asynchronous active-high reset
//   in_start                 : begin a load sequence (only honoured in IDLE)
//   in_coefficient[_valid]   : coefficient beat and its valid
//   out_coefficient_ready    : beat accepted this cycle when valid is high
//   out_clause_coefficients  : assembled vector, coefficient j at [j*C +: C]
//   out_clause_index         : target clause in WRITE, all-ones otherwise
//   out_busy                 : high in COLLECT and WRITE
//   out_done                 : one-cycle pulse after the last clause write
// All outputs are registered.
// -----------------------------------------------------------------------------
module clause_loader
   import clause_loader_pkg::*;
#(
   parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT = 2,
   parameter int NUMBER_OF_INTEGER_VARIABLES              = 2,
   parameter int NUMBER_OF_CLAUSES                        = 2,
   parameter int MAX_BIT_WIDTH_OF_CLAUSES_INDEX           = 1
) (
   input  logic                                   in_clk,
   input  logic                                   in_reset,
   input  logic                                   in_start,
   input  logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT-1:0] in_coefficient,
   input  logic                                   in_coefficient_valid,
   output logic                                   out_coefficient_ready,
   output logic [MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT*(NUMBER_OF_INTEGER_VARIABLES+1)-1:0]
                                                  out_clause_coefficients,
   output logic [MAX_BIT_WIDTH_OF_CLAUSES_INDEX:0] out_clause_index,
   output logic                                   out_busy,
   output logic                                   out_done
);

   localparam int C  = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT;
   localparam int K  = coeffs_per_clause(NUMBER_OF_INTEGER_VARIABLES);
   localparam int IW = MAX_BIT_WIDTH_OF_CLAUSES_INDEX + 1;
   localparam logic [IW-1:0] IDLE_IDX  = IDLE_INDEX[IW-1:0];
   localparam logic [IW-1:0] LAST_IDX  = IW'(NUMBER_OF_CLAUSES - 1);

   state_t          state;
   logic [IW-1:0]   clause_count;
   logic            accept;
   logic            beat_last;
   logic            assembler_clear;
   logic [C*K-1:0]  vector_next;

   // ready is a registered decode of COLLECT, so this is a clean handshake.
   assign accept          = in_coefficient_valid & out_coefficient_ready;
   assign assembler_clear = (state == ST_IDLE) & in_start;

   clause_loader_assembler #(
      .C (C),
      .K (K)
   ) u_assembler (
      .in_clk          (in_clk),
      .in_reset        (in_reset),
      .in_clear        (assembler_clear),
      .in_accept       (accept),
      .in_coefficient  (in_coefficient),
      .out_beat_last   (beat_last),
      .out_vector_next (vector_next)
   );

   // Outputs are set on the transition into each state so they are valid in
   // the very cycle the state is entered.
   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         state                   <= ST_IDLE;
         clause_count            <= '0;
         out_coefficient_ready   <= 1'b0;
         out_clause_coefficients <= '0;
         out_clause_index        <= IDLE_IDX;
         out_busy                <= 1'b0;
         out_done                <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               out_done <= 1'b0;
               if (in_start) begin
                  state                 <= ST_COLLECT;
                  clause_count          <= '0;
                  out_coefficient_ready <= 1'b1;
                  out_busy              <= 1'b1;
               end
            end
            ST_COLLECT: begin
               if (accept && beat_last) begin
                  state                   <= ST_WRITE;
                  out_coefficient_ready   <= 1'b0;
                  out_clause_index        <= clause_count;
                  out_clause_coefficients <= vector_next;
               end
            end
            ST_WRITE: begin
               // Index is live for this single cycle only.
               out_clause_index <= IDLE_IDX;
               if (clause_count == LAST_IDX) begin
                  state    <= ST_DONE;
                  out_busy <= 1'b0;
                  out_done <= 1'b1;
               end else begin
                  state                 <= ST_COLLECT;
                  clause_count          <= clause_count + IW'(1);
                  out_coefficient_ready <= 1'b1;
               end
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               out_done <= 1'b0;
            end
            default: begin
               state                 <= ST_IDLE;
               out_coefficient_ready <= 1'b0;
               out_clause_index      <= IDLE_IDX;
               out_busy              <= 1'b0;
               out_done              <= 1'b0;
            end
         endcase
      end
   end

endmodule
